// File: rtl/rpm_meter_multi_if.sv
// Pin-side and result-side signals of the multi-channel encoder speed meter.
interface rpm_meter_multi_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned RPM_W = 16
);
    logic                    en;
    logic [N_CH-1:0]         enc_a;
    logic [N_CH-1:0]         enc_b;
    logic [N_CH*RPM_W-1:0]   rpm;
    logic [N_CH-1:0]         dir;
    logic                    rpm_valid;
    logic                    gate_tick;

    modport master (
        output en, enc_a, enc_b,
        input  rpm, dir, rpm_valid, gate_tick
    );

    modport slave (
        input  en, enc_a, enc_b,
        output rpm, dir, rpm_valid, gate_tick
    );
endinterface

// File: rtl/rpm_meter_multi.sv
// Multi-channel quadrature encoder speed meter.
// Counts signed encoder edges per channel over a fixed gate window, then converts
// each snapshot to an RPM magnitude and direction with one shared multiplier.
// Optional feature macro: RPM_QUAD_X4_EN selects 4x Gray-code decoding; when it is
// undefined only rising edges of phase A are counted (1x decoding).
module rpm_meter_multi #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned RPM_W       = 16,
    parameter int unsigned GATE_CYCLES = 17500000,
    parameter int unsigned K_MUL       = 37449,
    parameter int unsigned K_SHIFT     = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    rpm_meter_multi_if.slave   bus
);

    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned PROD_W = CNT_W + 18;
    localparam logic signed [CNT_W:0] SUM_MAX = (CNT_W + 1)'((2 ** (CNT_W - 1)) - 1);
    localparam logic signed [CNT_W:0] SUM_MIN = -SUM_MAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [N_CH-1:0]          a_s1, a_s2, a_d;
    logic [N_CH-1:0]          b_s1, b_s2;
`ifdef RPM_QUAD_X4_EN
    logic [N_CH-1:0]          b_d;
`endif
    logic signed [1:0]        inc_c   [N_CH];
    logic signed [CNT_W-1:0]  sat_c   [N_CH];
    logic signed [CNT_W:0]    sum_c   [N_CH];
    logic signed [CNT_W-1:0]  live_q  [N_CH];
    logic signed [CNT_W-1:0]  snap_q  [N_CH];
    logic [GATE_W-1:0]        gate_q;
    logic                     tick_c;
    logic                     gate_tick_q;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic                     rpm_valid_q, rpm_valid_d;
    logic                     conv_we_c;

    logic signed [CNT_W-1:0]  sel_c;
    logic [CNT_W-1:0]         mag_c;
    logic [PROD_W-1:0]        prod_c;
    logic [PROD_W-1:0]        shift_c;
    logic [RPM_W-1:0]         rpm_c;
    logic [RPM_W-1:0]         rpm_q   [N_CH];
    logic [N_CH-1:0]          dir_q;

    // Two-stage synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1 <= '0;
            a_s2 <= '0;
            a_d  <= '0;
            b_s1 <= '0;
            b_s2 <= '0;
`ifdef RPM_QUAD_X4_EN
            b_d  <= '0;
`endif
        end else begin
            a_s1 <= bus.enc_a;
            a_s2 <= a_s1;
            a_d  <= a_s2;
            b_s1 <= bus.enc_b;
            b_s2 <= b_s1;
`ifdef RPM_QUAD_X4_EN
            b_d  <= b_s2;
`endif
        end
    end

    // Per-channel signed increment and saturating next count.
    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            inc_c[i] = 2'sb00;
`ifdef RPM_QUAD_X4_EN
            case ({a_d[i], b_d[i], a_s2[i], b_s2[i]})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: inc_c[i] = 2'sb01;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: inc_c[i] = 2'sb11;
                default:                            inc_c[i] = 2'sb00;
            endcase
`else
            if (a_s2[i] && !a_d[i]) begin
                inc_c[i] = b_s2[i] ? 2'sb11 : 2'sb01;
            end
`endif
            sum_c[i] = (CNT_W + 1)'(live_q[i]) + (CNT_W + 1)'(inc_c[i]);
            if (sum_c[i] > SUM_MAX) begin
                sat_c[i] = CNT_W'(SUM_MAX);
            end else if (sum_c[i] < SUM_MIN) begin
                sat_c[i] = CNT_W'(SUM_MIN);
            end else begin
                sat_c[i] = CNT_W'(sum_c[i]);
            end
        end
    end

    assign tick_c = bus.en && (gate_q == GATE_W'(GATE_CYCLES - 1));

    // Gate window timer; cleared and held while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_q      <= '0;
            gate_tick_q <= 1'b0;
        end else begin
            gate_tick_q <= tick_c;
            if (!bus.en || tick_c) begin
                gate_q <= '0;
            end else begin
                gate_q <= gate_q + GATE_W'(1);
            end
        end
    end

    // Live edge counters and end-of-window snapshots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (!bus.en) begin
                    live_q[i] <= '0;
                end else if (tick_c) begin
                    snap_q[i] <= live_q[i];
                    live_q[i] <= CNT_W'(inc_c[i]);
                end else begin
                    live_q[i] <= sat_c[i];
                end
            end
        end
    end

    // Conversion FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            rpm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            rpm_valid_q <= rpm_valid_d;
        end
    end

    // Conversion FSM next state: one channel per cycle, then a valid strobe.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        rpm_valid_d = 1'b0;
        conv_we_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_c) begin
                    state_d = ST_CONV;
                    ch_d    = '0;
                end
            end
            ST_CONV: begin
                conv_we_c = 1'b1;
                if (ch_q == CH_W'(N_CH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            ST_DONE: begin
                rpm_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shared scaler: |count| * K_MUL >> K_SHIFT, clipped to the output range.
    always_comb begin
        sel_c   = snap_q[ch_q];
        mag_c   = sel_c[CNT_W-1] ? $unsigned(-sel_c) : $unsigned(sel_c);
        prod_c  = PROD_W'(mag_c) * PROD_W'(K_MUL);
        shift_c = prod_c >> K_SHIFT;
        rpm_c   = (|shift_c[PROD_W-1:RPM_W]) ? '1 : shift_c[RPM_W-1:0];
    end

    // Result registers; hold between conversions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                rpm_q[i] <= '0;
            end
            dir_q <= '0;
        end else if (conv_we_c) begin
            rpm_q[ch_q] <= rpm_c;
            dir_q[ch_q] <= ~sel_c[CNT_W-1];
        end
    end

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_out
        assign bus.rpm[g*RPM_W +: RPM_W] = rpm_q[g];
    end
    assign bus.dir       = dir_q;
    assign bus.rpm_valid = rpm_valid_q;
    assign bus.gate_tick = gate_tick_q;

endmodule
